// File: rtl/comp_sequencer.sv
// Control sequencer for the computation datapath (serial MAC, 3x3 and 2x2 systolic arrays).
// Latches a mode on start, then steps CLEAR/FEED/DRAIN/OUTPUT/DONE while driving the datapath controls.
module comp_sequencer #(
  parameter int unsigned SER_LEN = 9,
  parameter int unsigned P1_FEED = 5,
  parameter int unsigned P1_OUT  = 9,
  parameter int unsigned P2_FEED = 3,
  parameter int unsigned P2_OUT  = 4,
  parameter int unsigned DRAIN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       abort,
  output logic [1:0] sel_m,
  output logic       mux_reset,
  output logic       P1_en,
  output logic [1:0] P2_en,
  output logic [2:0] c_sel,
  output logic       feed_valid,
  output logic [3:0] feed_idx,
  output logic       out_valid,
  output logic [3:0] out_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_t;

  localparam logic [1:0] M_SER = 2'b01;
  localparam logic [1:0] M_P1  = 2'b10;
  localparam logic [1:0] M_P2  = 2'b11;

  localparam logic [3:0] SER_LAST   = 4'(SER_LEN - 1);
  localparam logic [3:0] P1_F_LAST  = 4'(P1_FEED - 1);
  localparam logic [3:0] P1_O_LAST  = 4'(P1_OUT - 1);
  localparam logic [3:0] P2_F_LAST  = 4'(P2_FEED - 1);
  localparam logic [3:0] P2_O_LAST  = 4'(P2_OUT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

  state_t     state_q, state_d;
  logic [1:0] m_q, m_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] feed_last;
  logic [3:0] out_last;
  logic       systolic;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal counts per latched mode; serial mode produces a single result word.
  always_comb begin
    feed_last = '0;
    out_last  = '0;
    case (m_q)
      M_SER: begin
        feed_last = SER_LAST;
        out_last  = '0;
      end
      M_P1: begin
        feed_last = P1_F_LAST;
        out_last  = P1_O_LAST;
      end
      M_P2: begin
        feed_last = P2_F_LAST;
        out_last  = P2_O_LAST;
      end
      default: begin
        feed_last = '0;
        out_last  = '0;
      end
    endcase
  end

  assign systolic = (m_q == M_P1) || (m_q == M_P2);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      m_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (mode != 2'b00)) begin
            m_d     = mode;
            cnt_d   = '0;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_d   = '0;
          state_d = S_FEED;
        end
        S_FEED: begin
          if (cnt_q == feed_last) begin
            cnt_d   = '0;
            state_d = systolic ? S_DRAIN : S_OUTPUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = S_OUTPUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_OUTPUT: begin
          if (cnt_q == out_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          m_d     = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          m_d     = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only state/counter/mode registers, so IDLE (and reset) reads all zeros.
  always_comb begin
    sel_m      = '0;
    mux_reset  = 1'b0;
    P1_en      = 1'b0;
    P2_en      = '0;
    c_sel      = '0;
    feed_valid = 1'b0;
    feed_idx   = '0;
    out_valid  = 1'b0;
    out_idx    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_CLEAR: begin
        sel_m     = m_q;
        busy      = 1'b1;
        mux_reset = (m_q == M_SER);
      end
      S_FEED: begin
        sel_m      = m_q;
        busy       = 1'b1;
        feed_valid = 1'b1;
        feed_idx   = cnt_q;
        P1_en      = (m_q == M_P1);
        P2_en      = (m_q == M_P2) ? 2'b01 : 2'b00;
      end
      S_DRAIN: begin
        sel_m = m_q;
        busy  = 1'b1;
        P1_en = (m_q == M_P1);
        P2_en = (m_q == M_P2) ? 2'b01 : 2'b00;
      end
      S_OUTPUT: begin
        sel_m     = m_q;
        busy      = 1'b1;
        out_valid = 1'b1;
        out_idx   = cnt_q;
        P2_en     = (m_q == M_P2) ? 2'b10 : 2'b00;
        c_sel     = (m_q == M_P2) ? cnt_q[2:0] : 3'b000;
      end
      S_DONE: begin
        sel_m = m_q;
        busy  = 1'b1;
        done  = 1'b1;
      end
      default: begin
        sel_m = '0;
      end
    endcase
  end

endmodule
